// File: rtl/dpi_array_xfer_if.sv
// Bundle of the request, element, call, return and response channels.
// Signal suffixes are written from the transfer engine's point of view
// (_i = into the engine, _o = out of the engine).
interface dpi_array_xfer_if #(
  parameter int N_ELEM = 4,
  parameter int ELEM_W = 32,
  parameter int RET_W  = 32,
  parameter int FID_W  = 8
);
  localparam int CNT_W = $clog2(N_ELEM + 1);

  // call request
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [1:0]                req_mode_i;
  logic [FID_W-1:0]          req_fid_i;
  logic [CNT_W-1:0]          req_n_i;
  logic [N_ELEM*ELEM_W-1:0]  req_data_i;
  // outbound elements
  logic                      elem_valid_o;
  logic                      elem_ready_i;
  logic [ELEM_W-1:0]         elem_data_o;
  logic [CNT_W-1:0]          elem_idx_o;
  logic                      elem_last_o;
  // call issue
  logic                      call_valid_o;
  logic                      call_ready_i;
  logic [FID_W-1:0]          call_fid_o;
  logic [CNT_W-1:0]          call_n_o;
  // return value
  logic                      ret_valid_i;
  logic                      ret_ready_o;
  logic [RET_W-1:0]          ret_value_i;
  // returned elements
  logic                      relem_valid_i;
  logic                      relem_ready_o;
  logic [ELEM_W-1:0]         relem_data_i;
  // response
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [RET_W-1:0]          rsp_value_o;
  logic [N_ELEM*ELEM_W-1:0]  rsp_data_o;
  logic                      rsp_err_o;

  // transfer engine side
  modport slave (
    input  req_valid_i, req_mode_i, req_fid_i, req_n_i, req_data_i,
    input  elem_ready_i, call_ready_i, ret_valid_i, ret_value_i,
    input  relem_valid_i, relem_data_i, rsp_ready_i,
    output req_ready_o, elem_valid_o, elem_data_o, elem_idx_o, elem_last_o,
    output call_valid_o, call_fid_o, call_n_o, ret_ready_o, relem_ready_o,
    output rsp_valid_o, rsp_value_o, rsp_data_o, rsp_err_o
  );

  // requester / DPI-side agent
  modport master (
    output req_valid_i, req_mode_i, req_fid_i, req_n_i, req_data_i,
    output elem_ready_i, call_ready_i, ret_valid_i, ret_value_i,
    output relem_valid_i, relem_data_i, rsp_ready_i,
    input  req_ready_o, elem_valid_o, elem_data_o, elem_idx_o, elem_last_o,
    input  call_valid_o, call_fid_o, call_n_o, ret_ready_o, relem_ready_o,
    input  rsp_valid_o, rsp_value_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/dpi_array_xfer.sv
// Array-argument transfer engine for a DPI-style call: captures a request,
// streams input elements out, issues the call, collects the return value and
// any output elements, then presents a single response.
module dpi_array_xfer #(
  parameter int N_ELEM = 4,
  parameter int ELEM_W = 32,
  parameter int RET_W  = 32,
  parameter int FID_W  = 8,
  localparam int CNT_W = $clog2(N_ELEM + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dpi_array_xfer_if.slave       bus,
  output logic                  busy_o,
  output logic [31:0]           call_cnt_o
);

  localparam logic [1:0] MODE_IN    = 2'd0;
  localparam logic [1:0] MODE_OUT   = 2'd1;
  localparam logic [1:0] MODE_INOUT = 2'd2;
  localparam logic [1:0] MODE_BAD   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_CALL,
    ST_WAIT_RET,
    ST_RECV,
    ST_RESP
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [FID_W-1:0]         fid_q, fid_d;
  logic [CNT_W-1:0]         n_q, n_d;
  logic [CNT_W-1:0]         idx_q, idx_d;
  logic [N_ELEM*ELEM_W-1:0] buf_q, buf_d;
  logic [RET_W-1:0]         ret_q, ret_d;
  logic                     err_q, err_d;
  logic [31:0]              cnt_q, cnt_d;

  // handshake outputs are flops loaded from the next state, so no input
  // ever reaches its own counterpart output combinationally
  logic req_ready_q, req_ready_d;
  logic elem_valid_q, elem_valid_d;
  logic call_valid_q, call_valid_d;
  logic ret_ready_q, ret_ready_d;
  logic relem_ready_q, relem_ready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic busy_q, busy_d;

  logic [ELEM_W-1:0] elem_arr [N_ELEM];
  logic [ELEM_W-1:0] elem_sel;
  logic [CNT_W-1:0]  n_last;
  logic              req_bad;
  logic              req_has_in;
  logic              mode_has_out;

  // view of the buffer as individual elements
  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_elem
      assign elem_arr[gi] = buf_q[gi*ELEM_W +: ELEM_W];
    end
  endgenerate

  assign n_last       = n_q - CNT_W'(1);
  assign req_bad      = (bus.req_mode_i == MODE_BAD) || (bus.req_n_i > CNT_W'(N_ELEM));
  assign req_has_in   = ((bus.req_mode_i == MODE_IN) || (bus.req_mode_i == MODE_INOUT))
                        && (bus.req_n_i != '0);
  assign mode_has_out = ((mode_q == MODE_OUT) || (mode_q == MODE_INOUT)) && (n_q != '0);

  // element mux for the SEND channel; index only moves on a handshake
  always_comb begin
    elem_sel = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (idx_q == CNT_W'(i)) elem_sel = elem_arr[i];
    end
  end

  // next-state and datapath updates for the transfer sequence
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fid_d   = fid_q;
    n_d     = n_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    ret_d   = ret_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          mode_d = bus.req_mode_i;
          fid_d  = bus.req_fid_i;
          n_d    = bus.req_n_i;
          idx_d  = '0;
          if (req_bad) begin
            // malformed call: echo the captured data back with an error
            buf_d   = bus.req_data_i;
            ret_d   = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            buf_d   = (bus.req_mode_i == MODE_OUT) ? '0 : bus.req_data_i;
            err_d   = 1'b0;
            state_d = req_has_in ? ST_SEND : ST_CALL;
          end
        end
      end
      ST_SEND: begin
        if (bus.elem_ready_i) begin
          if (idx_q == n_last) begin
            idx_d   = '0;
            state_d = ST_CALL;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      ST_CALL: begin
        if (bus.call_ready_i) state_d = ST_WAIT_RET;
      end
      ST_WAIT_RET: begin
        if (bus.ret_valid_i) begin
          ret_d   = bus.ret_value_i;
          cnt_d   = cnt_q + 32'd1;
          idx_d   = '0;
          state_d = mode_has_out ? ST_RECV : ST_RESP;
        end
      end
      ST_RECV: begin
        if (bus.relem_valid_i) begin
          for (int i = 0; i < N_ELEM; i++) begin
            if (idx_q == CNT_W'(i)) buf_d[i*ELEM_W +: ELEM_W] = bus.relem_data_i;
          end
          if (idx_q == n_last) begin
            idx_d   = '0;
            state_d = ST_RESP;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d   = (state_d == ST_IDLE);
    elem_valid_d  = (state_d == ST_SEND);
    call_valid_d  = (state_d == ST_CALL);
    ret_ready_d   = (state_d == ST_WAIT_RET);
    relem_ready_d = (state_d == ST_RECV);
    rsp_valid_d   = (state_d == ST_RESP);
    busy_d        = (state_d != ST_IDLE);
  end

  // state, datapath and registered handshake outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_IN;
      fid_q         <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      buf_q         <= '0;
      ret_q         <= '0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      elem_valid_q  <= 1'b0;
      call_valid_q  <= 1'b0;
      ret_ready_q   <= 1'b0;
      relem_ready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      fid_q         <= fid_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      ret_q         <= ret_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      elem_valid_q  <= elem_valid_d;
      call_valid_q  <= call_valid_d;
      ret_ready_q   <= ret_ready_d;
      relem_ready_q <= relem_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ready_o   = req_ready_q;
  assign bus.elem_valid_o  = elem_valid_q;
  assign bus.elem_data_o   = elem_sel;
  assign bus.elem_idx_o    = idx_q;
  assign bus.elem_last_o   = elem_valid_q && (idx_q == n_last);
  assign bus.call_valid_o  = call_valid_q;
  assign bus.call_fid_o    = fid_q;
  assign bus.call_n_o      = n_q;
  assign bus.ret_ready_o   = ret_ready_q;
  assign bus.relem_ready_o = relem_ready_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_value_o   = ret_q;
  assign bus.rsp_data_o    = buf_q;
  assign bus.rsp_err_o     = err_q;
  assign busy_o            = busy_q;
  assign call_cnt_o        = cnt_q;

endmodule

// File: doc/dpi_array_xfer.md
DPI_ARRAY_XFER -- requirements
Module: dpi_array_xfer

Interface
REQ-001 SHALL have parameter N_ELEM, default 4, maximum array elements per call (>=1).
REQ-002 SHALL have parameter ELEM_W, default 32, bits per element.
REQ-003 SHALL have parameter RET_W, default 32, bits of the DPI return value.
REQ-004 SHALL have parameter FID_W, default 8, bits of the function identifier; CNT_W = $clog2(N_ELEM+1).
REQ-005 SHALL have ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i / req_ready_o  in/out  1  call request handshake.
- req_mode_i  in  2  0=IN, 1=OUT, 2=INOUT, 3=illegal.
- req_fid_i  in  FID_W  function id.
- req_n_i  in  CNT_W  element count.
- req_data_i  in  N_ELEM*ELEM_W  packed array; element i = [i*ELEM_W +: ELEM_W].
- elem_valid_o / elem_ready_i  out/in  1  outbound element handshake.
- elem_data_o  out  ELEM_W;  elem_idx_o  out  CNT_W;  elem_last_o  out  1.
- call_valid_o / call_ready_i  out/in  1  call issue handshake.
- call_fid_o  out  FID_W;  call_n_o  out  CNT_W.
- ret_valid_i / ret_ready_o  in/out  1;  ret_value_i  in  RET_W  return value.
- relem_valid_i / relem_ready_o  in/out  1;  relem_data_i  in  ELEM_W  returned element.
- rsp_valid_o / rsp_ready_i  out/in  1;  rsp_value_o  out  RET_W;  rsp_data_o  out  N_ELEM*ELEM_W;  rsp_err_o  out  1.
- busy_o  out  1  high in any state but IDLE.
- call_cnt_o  out  32  completed DPI calls, wrapping.

Function
REQ-006 SHALL implement FSM IDLE, SEND, CALL, WAIT_RET, RECV, RESP; every handshake completes on a cycle where valid&ready are both high.
REQ-007 IDLE: req_ready_o=1; on acceptance SHALL register mode, fid, n and data into an internal buffer.
REQ-008 Error: mode==3 or req_n_i>N_ELEM SHALL go directly to RESP with rsp_err_o=1, rsp_value_o=0, rsp_data_o=captured data; no element, call or ret traffic.
REQ-009 OUT mode SHALL zero the buffer at capture; IN and INOUT keep captured data.
REQ-010 IDLE->SEND when mode IN/INOUT and n>0; otherwise IDLE->CALL.
REQ-011 SEND: elements 0..n-1 presented in ascending order, one per handshake, elem_idx_o=index, elem_last_o=1 only at index n-1; data/idx SHALL stay stable while elem_valid_o=1 and elem_ready_i=0; after last handshake ->CALL.
REQ-012 CALL: call_valid_o=1 with call_fid_o, call_n_o held; on handshake ->WAIT_RET.
REQ-013 WAIT_RET: ret_ready_o=1; on handshake capture ret_value_i, increment call_cnt_o (wraps 0xFFFFFFFF->0); ->RECV if mode OUT/INOUT and n>0, else ->RESP.
REQ-014 RECV: relem_ready_o=1; k-th handshake (k=0..n-1) writes buffer element k; elements >=n untouched; after n-th ->RESP.
REQ-015 RESP: rsp_valid_o=1, rsp_err_o=0, rsp_value_o=captured return, rsp_data_o=buffer; all held stable until rsp_ready_i; then ->IDLE.
REQ-016 Minimum latency, all readies high, IN n=N_ELEM: request accept to rsp_valid_o = N_ELEM+3 cycles.
REQ-017 Ready/valid outputs SHALL be low in every state other than the one that owns them; no combinational path from any *_ready_i/*_valid_i to its own counterpart output.
REQ-018 New request SHALL NOT be accepted in the cycle the response completes (IDLE first).

Reset
REQ-019 While rst_i high: state IDLE, req_ready_o=1, all other valid/ready outputs 0, rsp_value_o=0, rsp_data_o=0, rsp_err_o=0, call_cnt_o=0, busy_o=0.
REQ-020 Reset asserted mid-transaction SHALL abort it immediately with no response; first request after release proceeds normally.

Verification
REQ-021 IN, n=4, data 128'hDEAD_BEEF_CAFE_BABE_1234_5678_9ABC_DEF0, ret 0x55 -> elements 0x9ABCDEF0,0x12345678,0xCAFEBABE,0xDEADBEEF idx 0..3, last at idx 3; call_n_o=4; rsp_value_o=0x55, rsp_data_o=input, call_cnt_o=1.
REQ-022 OUT, n=4, same data, relem 1,2,3,4 -> no elem_valid_o; rsp_data_o=128'h00000004_00000003_00000002_00000001.
REQ-023 INOUT, n=2, same data, relem 0xA,0xB -> two elements sent; rsp_data_o=128'hDEADBEEF_CAFEBABE_0000000B_0000000A.
REQ-024 n=5, then mode=3 -> each: rsp_err_o=1, rsp_value_o=0, no call_valid_o, call_cnt_o unchanged.
REQ-025 IN n=4 with elem_ready_i low alternate cycles and rsp_ready_i low 3 cycles -> stable outputs, same result as REQ-021; n=0 IN -> no elements, one call.
REQ-026 rst_i pulsed after 2nd SEND handshake -> no rsp, call_cnt_o=0, subsequent REQ-021 request passes.
